// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states and default limits.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_MAX_BURST = 32;
  localparam int unsigned DEF_BUSY_TO   = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping modulo N.
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx_sol among N_REQ byte-stream requesters with round-robin,
// message-locked arbitration and the tx en/rdy handshake.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned BUSY_TO   = DEF_BUSY_TO
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_en,
  input  logic                       tx_rdy,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       locked,
  output logic                       err_stall,
  input  logic                       err_clr
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(BUSY_TO + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [TW-1:0] to_q, to_d;

  logic [7:0]       data_arr [N_REQ];
  logic [N_REQ-1:0] owner_mask, elig, pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [7:0]       burst_cnt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_data
    assign data_arr[g] = req_data[8*g +: 8];
  end

  // While locked only the owner is eligible, even if its valid is low.
  always_comb begin
    owner_mask           = '0;
    owner_mask[gnt_id_q] = 1'b1;
    elig = locked_q ? (req_valid & owner_mask) : req_valid;
  end

  uart_tx_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    locked_d  = locked_q;
    to_d      = to_q;
    err_d     = err_clr ? 1'b0 : err_q;
    req_ready = '0;
    burst_cnt = cnt_q + 8'd1;
    unique case (state_q)
      ARB: begin
        if (tx_rdy && pick_any) begin
          req_ready = pick_oh;
          tx_data_d = data_arr[pick_idx];
          tx_en_d   = 1'b1;
          gnt_id_d  = pick_idx;
          rr_ptr_d  = pick_idx;
          to_d      = '0;
          state_d   = BUSY;
          if (req_last[pick_idx] || burst_cnt == 8'(MAX_BURST)) begin
            locked_d = 1'b0;
            cnt_d    = '0;
          end else begin
            locked_d = 1'b1;
            cnt_d    = burst_cnt;
          end
        end
      end
      BUSY: begin
        // to_q counts from the tx_en cycle, so a stall is flagged BUSY_TO cycles after it.
        if (!tx_rdy) begin
          state_d = DRAIN;
        end else if (to_q == TW'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DRAIN: begin
        if (tx_rdy) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= IW'(N_REQ - 1);
      gnt_id_q  <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_id_q  <= gnt_id_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_en     = tx_en_q;
  assign gnt_id    = gnt_id_q;
  assign locked    = locked_q;
  assign err_stall = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx_sol and requester queues.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last  = '0;
  logic [8*NR-1:0] req_data  = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_en;
  logic            tx_rdy = 1'b1;
  logic [1:0]      gnt_id;
  logic            locked;
  logic            err_stall;
  logic            err_clr = 1'b0;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [8:0]  rbuf [NR][32];
  int unsigned head [NR];
  int unsigned tail [NR];

  logic [7:0] log_data [64];
  logic [1:0] log_id   [64];
  logic       log_lock [64];
  int         log_cyc  [64];
  int         log_n = 0;

  logic       stall_mode = 1'b0;
  logic       watch_r2   = 1'b0;
  logic       r2_seen    = 1'b0;
  int         frame = 0;
  logic [NR-1:0] acc;

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4), .BUSY_TO(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_rdy    (tx_rdy),
    .gnt_id    (gnt_id),
    .locked    (locked),
    .err_stall (err_stall),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: rdy drops the cycle after en and stays low for 10 cycles.
  always @(posedge clk) begin
    if (stall_mode) tx_rdy <= 1'b1;
    else if (tx_en) begin
      tx_rdy <= 1'b0;
      frame  <= 9;
    end else if (!tx_rdy) begin
      if (frame == 0) tx_rdy <= 1'b1;
      else frame <= frame - 1;
    end
  end

  // Requester model and output monitor.
  always begin
    @(negedge clk);
    acc = req_valid & req_ready;
    if (watch_r2 && req_ready[2]) r2_seen = 1'b1;
    if (tx_en && log_n < 64) begin
      log_data[log_n] = tx_data;
      log_id[log_n]   = gnt_id;
      log_lock[log_n] = locked;
      log_cyc[log_n]  = cyc;
      log_n++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && head[i] != tail[i]) head[i]++;
      if (head[i] != tail[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = rbuf[i][head[i] % 32][7:0];
        req_last[i]       = rbuf[i][head[i] % 32][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  end

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rbuf[r][tail[r] % 32] = {l, d};
    tail[r]++;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_n < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) head[i] = tail[i];
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    log_n   = 0;
    r2_seen = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_en !== 1'b0) $display("FAIL rst_tx_en: got %b want 0", tx_en); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", tx_data); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready: got %b want 0000", req_ready); else passed++;
    checks++; if (gnt_id !== 2'd0) $display("FAIL rst_gnt_id: got %0d want 0", gnt_id); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked); else passed++;
    checks++; if (err_stall !== 1'b0) $display("FAIL rst_err_stall: got %b want 0", err_stall); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    wait_log(2, 200);
    checks++; if (log_n !== 2) $display("FAIL single_count: got %0d want 2", log_n); else passed++;
    checks++; if (log_data[0] !== 8'h41) $display("FAIL single_d0: got %h want 41", log_data[0]); else passed++;
    checks++; if (log_data[1] !== 8'h42) $display("FAIL single_d1: got %h want 42", log_data[1]); else passed++;
    checks++; if (log_lock[0] !== 1'b1) $display("FAIL single_lock0: got %b want 1", log_lock[0]); else passed++;
    checks++; if (log_lock[1] !== 1'b0) $display("FAIL single_lock1: got %b want 0", log_lock[1]); else passed++;
    checks++; if (log_id[1] !== 2'd0) $display("FAIL single_gnt: got %0d want 0", log_id[1]); else passed++;
    checks++; if (log_cyc[1] - log_cyc[0] !== 13) $display("FAIL single_gap: got %0d want 13", log_cyc[1] - log_cyc[0]); else passed++;
  endtask

  task automatic test_fairness();
    logic [7:0] exp_d [8];
    logic [1:0] exp_i [8];
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push(i, 8'h61 + 8'(i), 1'b1);
    for (int k = 0; k < 8; k++) begin
      exp_i[k] = 2'(k % 4);
      exp_d[k] = 8'h61 + 8'(k % 4);
    end
    wait_log(8, 400);
    checks++; if (log_n !== 8) $display("FAIL fair_count: got %0d want 8", log_n); else passed++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (log_data[k] !== exp_d[k] || log_id[k] !== exp_i[k])
        $display("FAIL fair_order[%0d]: got %h/id%0d want %h/id%0d", k, log_data[k], log_id[k], exp_d[k], exp_i[k]);
      else passed++;
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12; exp_d[3] = 8'h55;
    do_reset();
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    wait_log(1, 100);
    push(2, 8'h55, 1'b1);
    watch_r2 = 1'b1;
    wait_log(2, 100);
    repeat (20) @(negedge clk);
    push(1, 8'h12, 1'b1);
    wait_log(3, 100);
    watch_r2 = 1'b0;
    wait_log(4, 100);
    checks++; if (log_n !== 4) $display("FAIL lock_count: got %0d want 4", log_n); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_data[k] !== exp_d[k]) $display("FAIL lock_data[%0d]: got %h want %h", k, log_data[k], exp_d[k]);
      else passed++;
    end
    checks++; if (log_id[2] !== 2'd1) $display("FAIL lock_id2: got %0d want 1", log_id[2]); else passed++;
    checks++; if (log_id[3] !== 2'd2) $display("FAIL lock_id3: got %0d want 2", log_id[3]); else passed++;
    checks++; if (r2_seen !== 1'b0) $display("FAIL lock_r2_ready: got %b want 0", r2_seen); else passed++;
    checks++; if (log_lock[2] !== 1'b0) $display("FAIL lock_release: got %b want 0", log_lock[2]); else passed++;
  endtask

  task automatic test_burst();
    logic [7:0] exp_d [11];
    do_reset();
    for (int k = 0; k < 10; k++) push(0, 8'h80 + 8'(k), 1'b0);
    push(3, 8'hC3, 1'b1);
    for (int k = 0; k < 4; k++) exp_d[k] = 8'h80 + 8'(k);
    exp_d[4] = 8'hC3;
    for (int k = 5; k < 11; k++) exp_d[k] = 8'h80 + 8'(k - 1);
    wait_log(11, 400);
    checks++; if (log_n !== 11) $display("FAIL burst_count: got %0d want 11", log_n); else passed++;
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (log_data[k] !== exp_d[k]) $display("FAIL burst_data[%0d]: got %h want %h", k, log_data[k], exp_d[k]);
      else passed++;
    end
    checks++; if (log_lock[2] !== 1'b1) $display("FAIL burst_lock2: got %b want 1", log_lock[2]); else passed++;
    checks++; if (log_lock[3] !== 1'b0) $display("FAIL burst_lock3: got %b want 0", log_lock[3]); else passed++;
  endtask

  task automatic test_stall();
    int k = 0;
    int err_cyc;
    do_reset();
    stall_mode = 1'b1;
    push(1, 8'h77, 1'b1);
    push(2, 8'h78, 1'b1);
    wait_log(1, 100);
    while (!err_stall && k < 100) begin
      @(negedge clk);
      k++;
    end
    err_cyc = cyc;
    checks++; if (err_stall !== 1'b1) $display("FAIL stall_flag: got %b want 1", err_stall); else passed++;
    checks++; if (err_cyc - log_cyc[0] !== 16) $display("FAIL stall_delay: got %0d want 16", err_cyc - log_cyc[0]); else passed++;
    wait_log(2, 100);
    checks++; if (log_data[1] !== 8'h78) $display("FAIL stall_next: got %h want 78", log_data[1]); else passed++;
    checks++; if (log_cyc[1] - log_cyc[0] !== 18) $display("FAIL stall_rearb: got %0d want 18", log_cyc[1] - log_cyc[0]); else passed++;
    repeat (24) @(negedge clk);
    checks++; if (err_stall !== 1'b1) $display("FAIL stall_sticky: got %b want 1", err_stall); else passed++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_stall !== 1'b0) $display("FAIL stall_clr: got %b want 0", err_stall); else passed++;
    stall_mode = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(0, 8'h21, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h23, 1'b1);
    wait_log(2, 100);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) head[i] = tail[i];
    @(negedge clk);
    rst = 1'b0;
    checks++; if (locked !== 1'b0) $display("FAIL mid_locked: got %b want 0", locked); else passed++;
    checks++; if (gnt_id !== 2'd0) $display("FAIL mid_gnt: got %0d want 0", gnt_id); else passed++;
    repeat (20) @(negedge clk);
    checks++; if (log_n !== 2) $display("FAIL mid_no_en: got %0d want 2", log_n); else passed++;
    push(0, 8'h31, 1'b1);
    push(2, 8'h32, 1'b1);
    wait_log(3, 100);
    checks++; if (log_data[2] !== 8'h31) $display("FAIL mid_winner_data: got %h want 31", log_data[2]); else passed++;
    checks++; if (log_id[2] !== 2'd0) $display("FAIL mid_winner_id: got %0d want 0", log_id[2]); else passed++;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_burst();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_sol transmitter among N_REQ byte-stream requesters, e.g. command echo, gold-buffer dump and status reporter.
- Round-robin arbitration with per-message locking: a message of one or more bytes ending in a last-flagged byte is never interleaved with another requester's bytes.
- Owns the tx en/rdy handshake, including the case where rdy stays high for some cycles after the en pulse.
- Sits between the top-level command logic and uart_tx_sol.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 32, maximum bytes per grant before the lock is forcibly released (1..255).
- BUSY_TO, 16, cycles to wait for tx_rdy to fall after tx_en before declaring a stall (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  current byte ends the message.
- req_ready  out  N_REQ  combinational one-hot accept; a byte transfers when valid and ready are both high.
- tx_data  out  8  byte to uart_tx_sol data_in.
- tx_en  out  1  one-cycle pulse to uart_tx_sol en.
- tx_rdy  in  1  uart_tx_sol rdy.
- gnt_id  out  $clog2(N_REQ)  current/last owner.
- locked  out  1  message in progress.
- err_stall  out  1  sticky: tx_rdy never fell within BUSY_TO cycles.
- err_clr  in  1  clears err_stall.

Behaviour:
- Reset values:
  - Outputs: tx_en=0, tx_data=0, req_ready=0, gnt_id=0, locked=0, err_stall=0.
  - Internal: state=ARB, rr_ptr=N_REQ-1 (requester 0 wins first), byte count=0.
  - Reset mid-byte abandons the message. No further tx_en is issued; the transmitter finishes its byte on its own.
- States: ARB, BUSY, DRAIN.
- ARB:
  - Acceptance requires tx_rdy=1 and at least one eligible valid.
  - If locked=0, every requester is eligible. Winner = first valid searching from rr_ptr+1 with wrap modulo N_REQ.
  - If locked=1, only gnt_id is eligible. Other requesters wait even if the owner's valid is low; there is no lock timeout.
  - On acceptance in cycle t:
    - req_ready[w]=1 in cycle t.
    - tx_data<=req_data[w] and tx_en<=1, registered, so the pulse appears in cycle t+1.
    - gnt_id<=w, rr_ptr<=w, count<=count+1, state<=BUSY.
    - locked<=0 if req_last[w]=1 or count+1==MAX_BURST; otherwise locked<=1. count resets to 0 whenever locked is cleared.
  - tx_rdy=0 in ARB: no acceptance, req_ready all 0.
- BUSY:
  - tx_en is high only in the first cycle; tx_data holds its value.
  - tx_rdy=0: go to DRAIN.
  - tx_rdy still high after BUSY_TO cycles counted from the tx_en cycle: set err_stall=1 and go to DRAIN, treating the byte as sent.
- DRAIN: wait for tx_rdy=1, then go to ARB. The next tx_en is therefore never closer than 1 cycle after rdy rises.
- Throughput: one byte per uart frame plus at most 2 cycles.
- err_stall:
  - Set has priority over err_clr in the same cycle.
  - Cleared only by err_clr or rst.
- Forced release at MAX_BURST: the owner loses its lock and re-competes. The rr_ptr rotation means other waiting requesters win first.
- req_valid may drop at any time with no byte loss, since transfer happens only on valid&&ready.
- tx_data/req_data are 8-bit pass-through; no arithmetic. count is 8-bit and never wraps because MAX_BURST<=255.

Decomposition:
- Shared package/include next to uart_defs.v: state encodings (ARB, BUSY, DRAIN) and the default MAX_BURST/BUSY_TO values.
- One natural sub-module: rr_pick, a combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: one-hot winner and index. Reusable by other arbiters.

Test Plan:
- Single request: req0 sends bytes 0x41, 0x42 (last on 0x42) with a behavioural tx model (rdy falls 1 cycle after en, 10-cycle frame) -> tx_en pulses twice, tx_data 0x41 then 0x42, locked=1 after the first byte and 0 after the second, gnt_id=0.
- Contention and fairness: req0..req3 all valid with single-byte messages "a","b","c","d", held continuously -> output order a,b,c,d,a,...; no requester is served twice before the others.
- Lock integrity: req1 starts a 3-byte message 0x10,0x11,0x12; req2 asserts valid after the first byte, and req1's valid gaps for 5 cycles mid-message -> output 0x10,0x11,0x12 then req2's byte; req_ready[2] stays 0 throughout.
- MAX_BURST=4 with req0 streaming 10 bytes and no last, req3 waiting -> after the 4th req0 byte, req3's byte is sent, then req0 resumes.
- Stall: tx_rdy held high forever after en -> err_stall=1 exactly BUSY_TO cycles after tx_en; state returns to ARB; err_clr pulse -> err_stall=0.
- Reset mid-message: rst for 1 cycle during BUSY of byte 2 of 3 -> tx_en stays 0, locked=0, gnt_id=0; next contention req0 vs req2 is won by req0.
